// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling via a down-counting baud timer.
// Each byte is presented on rx_data with a rdy/clr_rdy handshake; framing and overrun errors pulse.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2 - 1);

  state_t      state;
  logic        rx_m, rx_s, rx_d;
  logic [1:0]  sync_age;
  logic        armed;
  logic [11:0] cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        tick;

  assign tick = (cnt == '0);

  // Edge detection stays disarmed until the synchroniser has flushed and shown a real high,
  // so a line that is already low when reset is released is not taken as a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
      sync_age <= '0;
      armed    <= 1'b0;
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      rx_d     <= rx_s;
      if (sync_age != 2'd3) sync_age <= sync_age + 2'd1;
      armed    <= armed | (sync_age[1] & rx_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
      if (clr_rdy) rdy <= 1'b0;

      case (state)
        IDLE: begin
          if (armed && rx_d && !rx_s) begin
            cnt   <= HALF;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt     <= FULL;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - 12'd1;
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            cnt       <= FULL;
            if (bit_cnt == 4'd7) state <= STOP;
          end else begin
            cnt <= cnt - 12'd1;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              // Set wins over a simultaneous clr_rdy; that case consumed the old byte, so no overrun.
              rx_data <= shift_reg;
              rdy     <= 1'b1;
              ovr_err <= rdy & ~clr_rdy;
              state   <= IDLE;
            end else begin
              frm_err <= 1'b1;
              state   <= WAIT_HI;
            end
          end else begin
            cnt <= cnt - 12'd1;
          end
        end
        WAIT_HI: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
